// File: rtl/stream_gen_if.sv
// AXI-Stream style output bundle of stream_gen: data, valid, last and the downstream ready.
interface stream_gen_if #(
    parameter int nb = 40
);
    logic [nb-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tlast;
    logic          out_tready;

    modport master (output out_tdata, output out_tvalid, output out_tlast, input out_tready);
    modport slave  (input out_tdata, input out_tvalid, input out_tlast, output out_tready);
endinterface

// File: rtl/stream_gen.sv
// Packetised counting-stream generator: num_pkts packets of pkt_len beats carrying a running word count.
// Optional macro STREAM_GEN_GAP_EN inserts LFSR-driven one-cycle valid gaps between beats.
module stream_gen #(
    parameter int n  = 5,
    parameter int nb = n * 8
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic [15:0]   pkt_len,
    input  logic [15:0]   num_pkts,
    output logic          busy,
    output logic          done,
    stream_gen_if.master  out
);
    typedef logic [nb-1:0] data_t;

`ifdef STREAM_GEN_GAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd3} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [15:0] r_num;
    logic [15:0] r_beat;
    logic [15:0] r_pkt;
    logic [31:0] r_word;
    logic        w_has_pkts;
    logic        w_last;
    logic        w_xfer;
    logic        w_end;
    logic        w_accept;

    // An empty run still spends one busy cycle in SEND, with valid held low, before FIN.
    assign w_has_pkts     = (r_num != 16'd0);
    assign w_accept       = (r_state == IDLE) && start;
    assign w_last         = (r_beat == r_len - 16'd1);
    assign out.out_tvalid = (r_state == SEND) && w_has_pkts;
    assign out.out_tlast  = out.out_tvalid && w_last;
    assign out.out_tdata  = data_t'(r_word);
    assign w_xfer         = out.out_tvalid && out.out_tready;
    assign w_end          = w_xfer && w_last && (r_pkt == r_num - 16'd1);
    assign busy           = (r_state != IDLE) && (r_state != FIN);
    assign done           = (r_state == FIN);

`ifdef STREAM_GEN_GAP_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= 16'hACE1;
        end else if (busy) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Gaps are only taken after a completed transfer, so valid is never withdrawn while stalled.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = SEND;
            end
            SEND: begin
                if (!w_has_pkts || w_end) w_next = FIN;
`ifdef STREAM_GEN_GAP_EN
                else if (w_xfer && r_lfsr[0]) w_next = GAP;
            end
            GAP: begin
                w_next = SEND;
`endif
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_len  <= 16'd0;
            r_num  <= 16'd0;
            r_beat <= 16'd0;
            r_pkt  <= 16'd0;
            r_word <= 32'd0;
        end else if (w_accept) begin
            r_len  <= (pkt_len == 16'd0) ? 16'd1 : pkt_len;
            r_num  <= num_pkts;
            r_beat <= 16'd0;
            r_pkt  <= 16'd0;
            r_word <= 32'd0;
        end else if (w_xfer) begin
            r_word <= r_word + 32'd1;
            if (w_last) begin
                r_beat <= 16'd0;
                r_pkt  <= r_pkt + 16'd1;
            end else begin
                r_beat <= r_beat + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_stream_gen.sv
// Self-checking bench for stream_gen: run-level reference model checked every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_stream_gen;
    localparam int NB = 40;

    logic        aclk     = 1'b0;
    logic        aresetn  = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] pkt_len  = 16'd0;
    logic [15:0] num_pkts = 16'd0;
    logic        busy;
    logic        done;

    stream_gen_if #(.nb(NB)) sif ();

    stream_gen #(.n(5), .nb(NB)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start    (start),
        .pkt_len  (pkt_len),
        .num_pkts (num_pkts),
        .busy     (busy),
        .done     (done),
        .out      (sif)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Run-level model: phase 0 idle, 1 running, 2 completion cycle.
    int            m_phase = 0;
    longint        m_idx   = 0;
    longint        m_total = 0;
    longint        m_L     = 1;
    bit            p_stall = 0;
    bit            p_xfer  = 0;
    bit            p_gap   = 0;
    bit            c_xfer;
    logic [NB-1:0] p_data  = '0;
    logic          p_last  = 1'b0;
    logic [NB-1:0] e_data;

    int log_data[$];
    bit log_last[$];
    int log_cyc[$];
    int done_cyc = -1;
    int gap_cnt  = 0;
    int acc_cyc  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
        done_cyc = -1;
        gap_cnt  = 0;
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_tvalid", {63'd0, sif.out_tvalid}, 64'd0);
            chk("rst_tlast", {63'd0, sif.out_tlast}, 64'd0);
            chk("rst_tdata", 64'(sif.out_tdata), 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_done", {63'd0, done}, 64'd0);
            m_phase = 0;
            p_stall = 0;
            p_xfer  = 0;
            p_gap   = 0;
        end else begin
            chk("busy", {63'd0, busy}, {63'd0, m_phase == 1});
            chk("done", {63'd0, done}, {63'd0, m_phase == 2});
            if (done) done_cyc = cyc;
            if (m_phase == 1 && m_total > 0) begin
`ifdef STREAM_GEN_GAP_EN
                if (!sif.out_tvalid) begin
                    gap_cnt++;
                    chk("gap_after_xfer", {62'd0, p_xfer, p_gap}, 64'd2);
                end
`else
                chk("tvalid_run", {63'd0, sif.out_tvalid}, 64'd1);
`endif
            end else begin
                chk("tvalid_idle", {63'd0, sif.out_tvalid}, 64'd0);
            end
            if (p_stall) chk("hold_valid", {63'd0, sif.out_tvalid}, 64'd1);
            if (sif.out_tvalid) begin
                e_data = m_idx[NB-1:0];
                chk("tdata", 64'(sif.out_tdata), 64'(e_data));
                chk("tlast", {63'd0, sif.out_tlast}, {63'd0, (m_idx % m_L) == m_L - 1});
                if (p_stall) begin
                    chk("hold_data", 64'(sif.out_tdata), 64'(p_data));
                    chk("hold_last", {63'd0, sif.out_tlast}, {63'd0, p_last});
                end
            end
            c_xfer = sif.out_tvalid && sif.out_tready;
            if (c_xfer) begin
                log_data.push_back(int'(sif.out_tdata[31:0]));
                log_last.push_back(sif.out_tlast);
                log_cyc.push_back(cyc);
            end
            p_gap   = (m_phase == 1) && (m_total > 0) && !sif.out_tvalid;
            p_stall = sif.out_tvalid && !sif.out_tready;
            p_data  = sif.out_tdata;
            p_last  = sif.out_tlast;
            p_xfer  = c_xfer;
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_L     = (pkt_len == 16'd0) ? 64'd1 : longint'(pkt_len);
                    m_total = m_L * longint'(num_pkts);
                    m_idx   = 0;
                end
                1: begin
                    if (m_total == 0) m_phase = 2;
                    else if (c_xfer) begin
                        m_idx++;
                        if (m_idx == m_total) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // mode 0: ready held high, 1: random ready, 2: ready low for 5 cycles after valid rises
    task automatic run(input int len, input int num, input int mode, input int budget);
        clear_logs();
        pkt_len  = 16'(len);
        num_pkts = 16'(num);
        start    = 1'b1;
        if (mode == 2) sif.out_tready = 1'b0;
        @(posedge aclk); #1;
        start   = 1'b0;
        acc_cyc = cyc;
        if (mode == 2) begin
            for (int k = 0; k < 5; k++) begin
                chk("stall_tvalid", {63'd0, sif.out_tvalid}, 64'd1);
                chk("stall_tdata", 64'(sif.out_tdata), 64'd0);
                @(posedge aclk); #1;
            end
            sif.out_tready = 1'b1;
        end
        for (int i = 0; i < budget && done_cyc < 0; i++) begin
            if (mode == 1) sif.out_tready = 1'($urandom_range(0, 1));
            @(posedge aclk); #1;
        end
        sif.out_tready = 1'b1;
        if (done_cyc < 0) chk("run_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        sif.out_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);

        // First edge out of reset accepts the start.
        aresetn = 1'b1;
        run(4, 2, 0, 100);
        chk("t1_count", 64'(log_data.size()), 64'd8);
        if (log_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t1_data", 64'(log_data[i]), 64'(i));
                chk("t1_last", {63'd0, log_last[i]}, {63'd0, (i == 3) || (i == 7)});
`ifndef STREAM_GEN_GAP_EN
                chk("t1_consecutive", 64'(log_cyc[i]), 64'(log_cyc[0] + i));
`endif
            end
            chk("t1_done_cycle", 64'(done_cyc), 64'(log_cyc[7] + 1));
        end

        run(3, 1, 2, 100);
        chk("t2_count", 64'(log_data.size()), 64'd3);
        for (int i = 0; i < log_data.size(); i++) chk("t2_data", 64'(log_data[i]), 64'(i));

        run(5, 0, 0, 50);
        chk("t3_no_beats", 64'(log_data.size()), 64'd0);
        chk("t3_done_cycle", 64'(done_cyc), 64'(acc_cyc + 1));

        run(0, 2, 0, 50);
        chk("t4_count", 64'(log_data.size()), 64'd2);
        for (int i = 0; i < log_data.size(); i++) chk("t4_last", {63'd0, log_last[i]}, 64'd1);

        // Reset mid-packet once beats 0..5 of a 10-beat packet have transferred.
        clear_logs();
        pkt_len = 16'd10; num_pkts = 16'd1; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && log_data.size() < 6; i++) begin
            @(posedge aclk); #1;
        end
        chk("t5_beats_before_reset", 64'(log_data.size()), 64'd6);
        aresetn = 1'b0;
        #1;
        chk("t5_tvalid_async", {63'd0, sif.out_tvalid}, 64'd0);
        chk("t5_busy_async", {63'd0, busy}, 64'd0);
        chk("t5_tdata_async", 64'(sif.out_tdata), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        run(4, 1, 0, 50);
        chk("t5_restart_count", 64'(log_data.size()), 64'd4);
        if (log_data.size() > 0) chk("t5_restart_data0", 64'(log_data[0]), 64'd0);

        // Start while busy is ignored; latched parameters rule.
        clear_logs();
        pkt_len = 16'd3; num_pkts = 16'd3; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        pkt_len = 16'd7; num_pkts = 16'd5; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && done_cyc < 0; i++) begin
            sif.out_tready = 1'($urandom_range(0, 1));
            @(posedge aclk); #1;
        end
        sif.out_tready = 1'b1;
        chk("t6_count", 64'(log_data.size()), 64'd9);

        // Start during the completion cycle is ignored.
        clear_logs();
        pkt_len = 16'd2; num_pkts = 16'd2; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge aclk); #1;
        end
        chk("t7_done_seen", {63'd0, done}, 64'd1);
        pkt_len = 16'd6; num_pkts = 16'd1; start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("t7_fin_start_ignored", {63'd0, busy}, 64'd0);
        chk("t7_count", 64'(log_data.size()), 64'd4);

        for (int r = 0; r < 4; r++) begin
            int len;
            int num;
            len = int'($urandom_range(1, 6));
            num = int'($urandom_range(1, 3));
            run(len, num, 1, 400);
            chk("rand_count", 64'(log_data.size()), 64'(len * num));
        end

`ifdef STREAM_GEN_GAP_EN
        run(16, 4, 1, 2000);
        chk("gap_count", 64'(log_data.size()), 64'd64);
        for (int i = 0; i < log_data.size(); i++) chk("gap_data", 64'(log_data[i]), 64'(i));
        chk("gap_seen", {63'd0, gap_cnt > 0}, 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
